// File: rtl/exc_arbiter_v2.sv
// Exception/interrupt arbiter for the memory stage: picks one event per cycle,
// drives the CP0 write pulses and redirect PC, and holds flush until fetch drains.
module exc_arbiter_v2 #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned INT_LINES   = 8,
    parameter logic [31:0] BOOT_BASE   = 32'hBFC0_0200,
    parameter logic [31:0] NORMAL_BASE = 32'h8000_0000,
    parameter logic [31:0] REFILL_OFF  = 32'h0000_0000,
    parameter logic [31:0] GENERAL_OFF = 32'h0000_0180,
    parameter logic [31:0] INT_OFF     = 32'h0000_0200
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            pc,
    input  logic                   in_delayslot,
    input  logic                   bev,
    input  logic                   iv,
    input  logic                   int_en,
    input  logic [INT_LINES-1:0]   int_req,
    input  logic [INT_LINES-1:0]   int_mask,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [5*NUM_SRC-1:0]   src_code,
    input  logic [NUM_SRC-1:0]     src_refill,
    input  logic [NUM_SRC-1:0]     src_bad_we,
    input  logic [32*NUM_SRC-1:0]  src_badvaddr,
    input  logic                   eret,
    input  logic [31:0]            epc_in,
    input  logic                   fetch_ok,
    input  logic                   icache_stall,
    input  logic                   inst_uncached,
    output logic                   exc_now,
    output logic                   flush,
    output logic                   wr_exp,
    output logic                   clear_exl,
    output logic [4:0]             exp_code,
    output logic [31:0]            epc,
    output logic [31:0]            badvaddr,
    output logic                   badvaddr_we,
    output logic [31:0]            exception_new_pc
);

    localparam int unsigned XW = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e          state_q, state_d;
    logic            flush_q, flush_d;
    logic            wr_exp_q, wr_exp_d;
    logic            clear_exl_q, clear_exl_d;
    logic            badvaddr_we_q, badvaddr_we_d;
    logic [CW-1:0]   exp_code_q, exp_code_d;
    logic [XW-1:0]   epc_q, epc_d;
    logic [XW-1:0]   badvaddr_q, badvaddr_d;
    logic [XW-1:0]   new_pc_q, new_pc_d;

    logic            int_hit;
    logic            src_any;
    logic [SW-1:0]   sel;
    logic [CW-1:0]   sel_code;
    logic [XW-1:0]   sel_bad;
    logic [XW-1:0]   vpc;
    logic [XW-1:0]   base;
    logic            drained;

    assign int_hit = int_en & (|(int_req & int_mask));
    assign src_any = |src_valid;
    assign vpc     = in_delayslot ? (pc - 32'h4) : pc;
    assign base    = bev ? BOOT_BASE : NORMAL_BASE;
    assign drained = fetch_ok | (~icache_stall & ~inst_uncached);
    assign exc_now = (state_q == IDLE) & (int_hit | src_any | eret);

    // Lowest-index valid source wins: scan downward so the last hit is index 0 side.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) sel = SW'(i);
        end
    end

    assign sel_code = src_code[int'(sel)*CW +: CW];
    assign sel_bad  = src_badvaddr[int'(sel)*XW +: XW];

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        wr_exp_d      = 1'b0;
        clear_exl_d   = 1'b0;
        badvaddr_we_d = 1'b0;
        badvaddr_d    = '0;
        exp_code_d    = exp_code_q;
        epc_d         = epc_q;
        new_pc_d      = new_pc_q;

        case (state_q)
            IDLE: begin
                if (exc_now) begin
                    flush_d = 1'b1;
                    state_d = FLUSH;
                    if (int_hit) begin
                        exp_code_d = '0;
                        epc_d      = vpc;
                        wr_exp_d   = 1'b1;
                        new_pc_d   = base + (iv ? INT_OFF : GENERAL_OFF);
                    end else if (src_any) begin
                        exp_code_d = sel_code;
                        epc_d      = vpc;
                        wr_exp_d   = 1'b1;
                        new_pc_d   = base + (src_refill[sel] ? REFILL_OFF : GENERAL_OFF);
                        if (src_bad_we[sel]) begin
                            badvaddr_we_d = 1'b1;
                            badvaddr_d    = sel_bad;
                        end
                    end else begin
                        clear_exl_d = 1'b1;
                        new_pc_d    = epc_in;
                    end
                end
            end
            FLUSH: begin
                if (drained) begin
                    flush_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                flush_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            flush_q       <= 1'b0;
            wr_exp_q      <= 1'b0;
            clear_exl_q   <= 1'b0;
            badvaddr_we_q <= 1'b0;
            exp_code_q    <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            new_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            wr_exp_q      <= wr_exp_d;
            clear_exl_q   <= clear_exl_d;
            badvaddr_we_q <= badvaddr_we_d;
            exp_code_q    <= exp_code_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            new_pc_q      <= new_pc_d;
        end
    end

    assign flush            = flush_q;
    assign wr_exp           = wr_exp_q;
    assign clear_exl        = clear_exl_q;
    assign badvaddr_we      = badvaddr_we_q;
    assign exp_code         = exp_code_q;
    assign epc              = epc_q;
    assign badvaddr         = badvaddr_q;
    assign exception_new_pc = new_pc_q;

endmodule
